sr_cmd_driver: RTL and testbench
================================

Name: sr_cmd_driver

Overview:
- Command-side driver for the team's synchronous SR flip-flop. It is the controller that produces s/r, where the flip-flop consumes them.
- Accepts set/reset/toggle commands over a valid/ready handshake and converts each into a clean pulse on s or r.
- Guarantees s and r are never high together.
- Confirms the result by watching the flip-flop's q output, and reports completion or error.

Parameters:
- PULSE_LEN, 2, number of cycles s or r is held high per command; legal range 1..15.
- TIMEOUT, 4, cycles allowed in CHECK for q_fb to reach the target before error; legal range 1..15.
- GAP, 1, dead cycles with s=r=0 after each command before the next is accepted; legal range 0..15.

Ports:
- ck  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_op  input  2  00 nop, 01 set, 10 reset, 11 toggle.
- cmd_ready  output  1  high only in IDLE.
- s  output  1  set line to the flip-flop; registered.
- r  output  1  reset line to the flip-flop; registered.
- q_fb  input  1  q of the driven flip-flop.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a command completes, whether it passed or failed.
- err  output  1  sticky; set on timeout; cleared only by rst.
- target  output  1  level the last command aimed for.

Behaviour:
Reset (asynchronous, takes effect immediately, including mid-pulse):
- State goes to IDLE.
- s=0, r=0, done=0, err=0, target=0, busy=0, cmd_ready=1.
- Counters are cleared.

State machine: IDLE, PULSE, CHECK, GAP.

Accept rule:
- A command is accepted on a rising edge where cmd_valid=1 and cmd_ready=1.
- cmd_op is sampled only on that edge.

IDLE, on accept:
- set: target<=1, s<=1, go to PULSE.
- reset: target<=0, r<=1, go to PULSE.
- toggle: target<=~q_fb as sampled on the accept edge, then drive s or r as for set/reset.
- nop: no line is driven; done pulses on the next cycle; go to GAP. target is unchanged.

PULSE:
- The active line stays high for exactly PULSE_LEN cycles, counted from the first cycle after the accept edge.
- After that, s<=0 and r<=0 and the state goes to CHECK.

CHECK (s=r=0):
- Each cycle compares q_fb to target.
- On match: done=1 for one cycle, then go to GAP.
- If there is no match after TIMEOUT cycles: err<=1, done=1 for one cycle, then go to GAP.

GAP:
- s=r=0 for GAP cycles, then return to IDLE.
- If GAP=0, return to IDLE on the cycle after done.

Invariants:
- s&r is never 1.
- s and r change only on ck edges (or on rst).
- cmd_valid is ignored while busy; no queueing.

Latency (set or reset, q_fb following one edge after s/r, defaults):
- accept edge N; s high in cycles N+1..N+2; CHECK entered at N+3; done at N+3; cmd_ready again at N+5.

Boundaries:
- A redundant set (q already 1) still pulses s, then passes CHECK on its first cycle.
- A q_fb glitch during PULSE is ignored; only CHECK samples it.
- err does not block later commands.
- Counter widths are 4 bits. A value outside its legal range is a configuration error; no check is made in RTL.

Optional Feature:
- Macro: SR_VERIFY_EN.
- Defined: the CHECK state, the TIMEOUT handling and err are built as described above.
- Undefined: CHECK is omitted. done pulses on the first cycle after PULSE ends, err is tied to 0, and q_fb is used only to resolve toggle.

Test Plan:
- Reset then set; q_fb follows s one edge later → s high exactly 2 cycles, done one pulse at accept+3, err=0, cmd_ready=1 at accept+5.
- q_fb=1, toggle → target=0, r pulses 2 cycles, s stays 0 throughout, done once.
- set with q_fb held at 0 (SR_VERIFY_EN) → err=1 and done after 4 CHECK cycles; a following reset still completes and err remains 1.
- cmd_valid held high with alternating set/reset ops → exactly one accept per IDLE visit, s&r never 1, GAP cycle observed between pulses.
- Assert rst asynchronously in the middle of an s pulse → s drops before the next ck edge, busy=0, err=0.
- nop → no s/r activity, done one cycle after accept, target unchanged.

Source files
------------

// File: rtl/sr_cmd_driver.sv
// ============================================================================
//  Module      : sr_cmd_driver
//  Description : Command-side driver for a synchronous SR flip-flop. Accepts
//                set / reset / toggle / nop commands over a valid/ready
//                handshake and turns each into a clean, fixed-length pulse on
//                s or r (never both). Optionally confirms the flip-flop result
//                through q_fb and flags a sticky error on timeout.
//
//  Optional    : `define SR_VERIFY_EN builds the CHECK state, the TIMEOUT
//                handling and the err flag. Without it CHECK is omitted, done
//                pulses on the first cycle after the pulse ends, err is tied
//                low and q_fb is only used to resolve toggle.
//
//  Ports       : ck         clock, all state updates on the rising edge
//                rst        asynchronous active-high reset
//                cmd_valid  command present
//                cmd_op     00 nop, 01 set, 10 reset, 11 toggle
//                cmd_ready  high only while idle
//                s, r       registered set / reset lines to the flip-flop
//                q_fb       q output of the driven flip-flop
//                busy       high in any state other than idle
//                done       one-cycle completion pulse (pass or fail)
//                err        sticky timeout flag, cleared only by rst
//                target     level the last command aimed for
//
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sr_cmd_driver #(
    parameter int PULSE_LEN = 2,   // 1..15 cycles of s/r high per command
    parameter int TIMEOUT   = 4,   // 1..15 CHECK cycles before error
    parameter int GAP       = 1    // 0..15 dead cycles after each command
) (
    input  logic       ck,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    output logic       s,
    output logic       r,
    input  logic       q_fb,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       target
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_pulse = 2'd1;
    localparam logic [1:0] c_st_check = 2'd2;
    localparam logic [1:0] c_st_gap   = 2'd3;

    localparam logic [1:0] c_op_nop    = 2'b00;
    localparam logic [1:0] c_op_set    = 2'b01;
    localparam logic [1:0] c_op_reset  = 2'b10;
    localparam logic [1:0] c_op_toggle = 2'b11;

    localparam logic [3:0] c_pulse_last   = 4'(PULSE_LEN - 1);
    localparam logic [3:0] c_timeout_last = 4'(TIMEOUT - 1);
    // GAP state entered with done still pending: done cycle plus GAP cycles.
    localparam logic [3:0] c_gap_with_done = 4'(GAP);
    // GAP state entered after done already shown in CHECK: GAP cycles only.
    localparam logic [3:0] c_gap_after_check = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

    logic [1:0] r_state;
    logic [3:0] r_cnt;
    logic       r_s;
    logic       r_r;
    logic       r_done;
    logic       r_target;

`ifdef SR_VERIFY_EN
    logic r_err;
    logic w_match;
    logic w_check_done;

    assign w_match      = (q_fb == r_target);
    // CHECK finishes on a match or on the last allowed cycle.
    assign w_check_done = (r_state == c_st_check) &&
                          (w_match || (r_cnt == c_timeout_last));
    // Completion from CHECK is reported in the same cycle q_fb is seen to
    // match, so that path is combinational; nop completion is registered.
    assign done = r_done | w_check_done;
    assign err  = r_err;
`else
    // Without feedback verification the timeout and CHECK encoding have no
    // effect; fold them into a sink so they do not dangle.
    logic w_unused;
    assign w_unused = ^{c_timeout_last, c_st_check};
    assign done = r_done;
    assign err  = 1'b0;
`endif

    assign s         = r_s;
    assign r         = r_r;
    assign target    = r_target;
    assign cmd_ready = (r_state == c_st_idle);
    assign busy      = (r_state != c_st_idle);

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_cnt    <= 4'd0;
            r_s      <= 1'b0;
            r_r      <= 1'b0;
            r_done   <= 1'b0;
            r_target <= 1'b0;
`ifdef SR_VERIFY_EN
            r_err    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            c_op_set: begin
                                r_target <= 1'b1;
                                r_s      <= 1'b1;
                                r_cnt    <= c_pulse_last;
                                r_state  <= c_st_pulse;
                            end
                            c_op_reset: begin
                                r_target <= 1'b0;
                                r_r      <= 1'b1;
                                r_cnt    <= c_pulse_last;
                                r_state  <= c_st_pulse;
                            end
                            c_op_toggle: begin
                                // Aim for the opposite of the current q.
                                r_target <= ~q_fb;
                                r_s      <= ~q_fb;
                                r_r      <= q_fb;
                                r_cnt    <= c_pulse_last;
                                r_state  <= c_st_pulse;
                            end
                            default: begin
                                // nop: no line driven, complete immediately.
                                r_done  <= 1'b1;
                                r_cnt   <= c_gap_with_done;
                                r_state <= c_st_gap;
                            end
                        endcase
                    end
                end

                c_st_pulse: begin
                    if (r_cnt == 4'd0) begin
                        r_s <= 1'b0;
                        r_r <= 1'b0;
`ifdef SR_VERIFY_EN
                        r_cnt   <= 4'd0;
                        r_state <= c_st_check;
`else
                        r_done  <= 1'b1;
                        r_cnt   <= c_gap_with_done;
                        r_state <= c_st_gap;
`endif
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

`ifdef SR_VERIFY_EN
                c_st_check: begin
                    if (w_check_done) begin
                        if (!w_match) begin
                            r_err <= 1'b1;
                        end
                        if (c_gap_with_done == 4'd0) begin
                            r_state <= c_st_idle;
                        end else begin
                            r_cnt   <= c_gap_after_check;
                            r_state <= c_st_gap;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
`endif

                c_st_gap: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sr_cmd_driver.sv
// ============================================================================
//  Module      : tb_sr_cmd_driver
//  Description : Directed self-checking bench for sr_cmd_driver with default
//                parameters (PULSE_LEN=2, TIMEOUT=4, GAP=1). A small SR
//                flip-flop model closes the q_fb loop one edge after s/r.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sr_cmd_driver;

`ifdef SR_VERIFY_EN
    localparam int   c_to_done_k = 6;     // done in 4th CHECK cycle
    localparam logic c_to_err    = 1'b1;
`else
    localparam int   c_to_done_k = 3;     // done right after the pulse
    localparam logic c_to_err    = 1'b0;
`endif

    logic       ck = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready;
    logic       s;
    logic       r;
    logic       q_fb;
    logic       busy;
    logic       done;
    logic       err;
    logic       target;

    logic       ff_q;
    logic       ff_hold;

    int n_vec = 0;
    int n_err = 0;

    sr_cmd_driver dut (
        .ck        (ck),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_ready (cmd_ready),
        .s         (s),
        .r         (r),
        .q_fb      (q_fb),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .target    (target)
    );

    always #5 ck = ~ck;

    // Flip-flop model: q follows s/r one edge later unless held.
    always @(posedge ck or posedge rst) begin
        if (rst) ff_q <= 1'b0;
        else if (!ff_hold) begin
            if (s)      ff_q <= 1'b1;
            else if (r) ff_q <= 1'b0;
        end
    end
    assign q_fb = ff_q;

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; ff_hold = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        n_vec++; if (s !== 1'b0)         begin n_err++; $display("FAIL reset_s got=%b exp=0", s); end
        n_vec++; if (r !== 1'b0)         begin n_err++; $display("FAIL reset_r got=%b exp=0", r); end
        n_vec++; if (done !== 1'b0)      begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
        n_vec++; if (err !== 1'b0)       begin n_err++; $display("FAIL reset_err got=%b exp=0", err); end
        n_vec++; if (target !== 1'b0)    begin n_err++; $display("FAIL reset_target got=%b exp=0", target); end
        n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    endtask

    // Set from q=0: s high cycles N+1..N+2, done at N+3, ready at N+5.
    task automatic test_set();
        cmd_valid = 1'b1; cmd_op = 2'b01;
        tick();                      // accept edge N, now in cycle N+1
        cmd_valid = 1'b0;
        n_vec++; if (s !== 1'b1)         begin n_err++; $display("FAIL set_s_n1 got=%b exp=1", s); end
        n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL set_ready_n1 got=%b exp=0", cmd_ready); end
        n_vec++; if (target !== 1'b1)    begin n_err++; $display("FAIL set_target got=%b exp=1", target); end
        tick();                      // N+2
        n_vec++; if (s !== 1'b1)         begin n_err++; $display("FAIL set_s_n2 got=%b exp=1", s); end
        n_vec++; if (done !== 1'b0)      begin n_err++; $display("FAIL set_done_n2 got=%b exp=0", done); end
        tick();                      // N+3
        n_vec++; if (s !== 1'b0)         begin n_err++; $display("FAIL set_s_n3 got=%b exp=0", s); end
        n_vec++; if (done !== 1'b1)      begin n_err++; $display("FAIL set_done_n3 got=%b exp=1", done); end
        n_vec++; if (err !== 1'b0)       begin n_err++; $display("FAIL set_err got=%b exp=0", err); end
        tick();                      // N+4
        n_vec++; if (done !== 1'b0)      begin n_err++; $display("FAIL set_done_n4 got=%b exp=0", done); end
        n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL set_ready_n4 got=%b exp=0", cmd_ready); end
        tick();                      // N+5
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL set_ready_n5 got=%b exp=1", cmd_ready); end
        n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL set_busy_n5 got=%b exp=0", busy); end
    endtask

    // Toggle with q=1: target 0, r pulses two cycles, s never high.
    task automatic test_toggle();
        int s_seen;
        int r_cycles;
        int done_cnt;
        s_seen = 0; r_cycles = 0; done_cnt = 0;
        n_vec++; if (q_fb !== 1'b1) begin n_err++; $display("FAIL tog_pre_q got=%b exp=1", q_fb); end
        cmd_valid = 1'b1; cmd_op = 2'b11;
        tick();
        cmd_valid = 1'b0;
        n_vec++; if (target !== 1'b0) begin n_err++; $display("FAIL tog_target got=%b exp=0", target); end
        for (int k = 1; k <= 5; k++) begin
            if (s) s_seen++;
            if (r) r_cycles++;
            if (done) done_cnt++;
            if (k < 5) tick();
        end
        n_vec++; if (s_seen !== 0)      begin n_err++; $display("FAIL tog_s_seen got=%0d exp=0", s_seen); end
        n_vec++; if (r_cycles !== 2)    begin n_err++; $display("FAIL tog_r_cycles got=%0d exp=2", r_cycles); end
        n_vec++; if (done_cnt !== 1)    begin n_err++; $display("FAIL tog_done_cnt got=%0d exp=1", done_cnt); end
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL tog_ready got=%b exp=1", cmd_ready); end
    endtask

    // Set with q stuck at 0, then a normal reset command.
    task automatic test_timeout();
        ff_hold = 1'b1;
        cmd_valid = 1'b1; cmd_op = 2'b01;
        tick();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            n_vec++;
            if (done !== (k == c_to_done_k)) begin
                n_err++; $display("FAIL to_done_k%0d got=%b exp=%b", k, done, (k == c_to_done_k));
            end
            if (k < 8) tick();
        end
        n_vec++; if (err !== c_to_err)   begin n_err++; $display("FAIL to_err got=%b exp=%b", err, c_to_err); end
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL to_ready got=%b exp=1", cmd_ready); end
        ff_hold = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'b10;
        tick();
        cmd_valid = 1'b0;
        n_vec++; if (r !== 1'b1)         begin n_err++; $display("FAIL to_rst_r got=%b exp=1", r); end
        tick(); tick();              // N+3
        n_vec++; if (done !== 1'b1)      begin n_err++; $display("FAIL to_rst_done got=%b exp=1", done); end
        tick(); tick();              // N+5
        n_vec++; if (err !== c_to_err)   begin n_err++; $display("FAIL to_rst_err got=%b exp=%b", err, c_to_err); end
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL to_rst_ready got=%b exp=1", cmd_ready); end
    endtask

    // cmd_valid held high, ops alternating set/reset at each accept.
    task automatic test_back_to_back();
        int   n_acc;
        int   both_hit;
        int   gaps;
        int   dones;
        logic acc;
        n_acc = 0; both_hit = 0; gaps = 0; dones = 0;
        cmd_valid = 1'b1; cmd_op = 2'b01;
        for (int i = 0; i < 20; i++) begin
            acc = cmd_ready;
            tick();
            if (acc) begin
                n_acc++;
                cmd_op = (cmd_op == 2'b01) ? 2'b10 : 2'b01;
            end
            if (s && r) both_hit++;
            if (done) dones++;
            if (busy && !s && !r && !done) gaps++;
        end
        cmd_valid = 1'b0;
        tick();
        n_vec++; if (n_acc !== 4)        begin n_err++; $display("FAIL b2b_accepts got=%0d exp=4", n_acc); end
        n_vec++; if (both_hit !== 0)     begin n_err++; $display("FAIL b2b_s_and_r got=%0d exp=0", both_hit); end
        n_vec++; if (gaps !== 4)         begin n_err++; $display("FAIL b2b_gaps got=%0d exp=4", gaps); end
        n_vec++; if (dones !== 4)        begin n_err++; $display("FAIL b2b_dones got=%0d exp=4", dones); end
        n_vec++; if (target !== 1'b0)    begin n_err++; $display("FAIL b2b_target got=%b exp=0", target); end
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got=%b exp=1", cmd_ready); end
    endtask

    // rst raised between edges while s is high.
    task automatic test_async_reset();
        cmd_valid = 1'b1; cmd_op = 2'b01;
        tick();
        cmd_valid = 1'b0;
        n_vec++; if (s !== 1'b1)         begin n_err++; $display("FAIL ar_pre_s got=%b exp=1", s); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (s !== 1'b0)         begin n_err++; $display("FAIL ar_s got=%b exp=0", s); end
        n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL ar_busy got=%b exp=0", busy); end
        n_vec++; if (err !== 1'b0)       begin n_err++; $display("FAIL ar_err got=%b exp=0", err); end
        n_vec++; if (target !== 1'b0)    begin n_err++; $display("FAIL ar_target got=%b exp=0", target); end
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL ar_ready got=%b exp=1", cmd_ready); end
        #1 rst = 1'b0;
        tick();
        n_vec++; if (s !== 1'b0)         begin n_err++; $display("FAIL ar_post_s got=%b exp=0", s); end
    endtask

    // nop after a set: no s/r, done at N+1, target kept, ready at N+3.
    task automatic test_nop();
        cmd_valid = 1'b1; cmd_op = 2'b01;
        tick();
        cmd_valid = 1'b0;
        repeat (4) tick();
        cmd_valid = 1'b1; cmd_op = 2'b00;
        tick();                      // N+1
        cmd_valid = 1'b0;
        n_vec++; if (done !== 1'b1)      begin n_err++; $display("FAIL nop_done_n1 got=%b exp=1", done); end
        n_vec++; if ({s, r} !== 2'b00)   begin n_err++; $display("FAIL nop_sr_n1 got=%b exp=00", {s, r}); end
        n_vec++; if (target !== 1'b1)    begin n_err++; $display("FAIL nop_target got=%b exp=1", target); end
        n_vec++; if (busy !== 1'b1)      begin n_err++; $display("FAIL nop_busy_n1 got=%b exp=1", busy); end
        tick();                      // N+2
        n_vec++; if (done !== 1'b0)      begin n_err++; $display("FAIL nop_done_n2 got=%b exp=0", done); end
        n_vec++; if ({s, r} !== 2'b00)   begin n_err++; $display("FAIL nop_sr_n2 got=%b exp=00", {s, r}); end
        tick();                      // N+3
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL nop_ready_n3 got=%b exp=1", cmd_ready); end
    endtask

    initial begin
        test_reset();
        test_set();
        test_toggle();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        test_nop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
